// File: rtl/afu_pkg.sv
// Shared types and constants for the transpose AFU datapath blocks.
package afu_pkg;

  localparam int CL_WIDTH      = 512;
  localparam int CTX_LEN_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/afu_credit_counter.sv
// Outstanding-transaction counter bounded by CREDITS; shared by the read and write sides.
module afu_credit_counter #(
  parameter int CREDITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic full_o,
  output logic underflow_o
);

  localparam int CNT_W = $clog2(CREDITS) + 1;

  logic [CNT_W-1:0] count_q;
  logic             dec_ok;

  // A release with nothing outstanding is not a real release: it is flagged and ignored.
  assign dec_ok      = dec_i & ~zero_o;
  assign zero_o      = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(CREDITS));
  assign underflow_o = dec_i & zero_o;

  // Count up on reserve, down on release; simultaneous reserve and release cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      unique case ({inc_i, dec_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/afu_write_drain.sv
// Drains transposed cache lines from the output FIFO into the write channel,
// one request per line at consecutive addresses, with credit-limited flow.
module afu_write_drain
  import afu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CREDITS    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [CTX_LEN_WIDTH-1:0] ctx_length,
  input  logic [CL_WIDTH-1:0]      fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_re,
  input  logic                     wr_req_almostfull,
  output logic                     wr_req_valid,
  output logic [ADDR_WIDTH-1:0]    wr_req_addr,
  output logic [CL_WIDTH-1:0]      wr_req_data,
  input  logic                     wr_rsp_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     rsp_error
);

  drain_state_t             state_q;
  logic [ADDR_WIDTH-1:0]    base_q;
  logic [CTX_LEN_WIDTH-1:0] len_q;
  logic [CTX_LEN_WIDTH-1:0] issued_q;
  logic                     wr_valid_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic                     rsp_error_q;
  logic                     armed_q;

  logic cred_zero;
  logic cred_full;
  logic cred_underflow;
  logic last_re;

  afu_credit_counter #(
    .CREDITS(CREDITS)
  ) u_credits (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (fifo_re),
    .dec_i      (wr_rsp_valid),
    .zero_o     (cred_zero),
    .full_o     (cred_full),
    .underflow_o(cred_underflow)
  );

  // Pop only when a line is available, the channel has room, the job is not
  // fully issued and a credit is free. The FIFO read-data then lines up with
  // the registered request valid one cycle later.
  assign fifo_re = (state_q == RUN) & ~fifo_empty & ~wr_req_almostfull &
                   (issued_q < len_q) & ~cred_full;

  assign last_re = fifo_re & ((issued_q + 32'd1) == len_q);

  assign wr_req_valid = wr_valid_q;
  assign wr_req_addr  = wr_addr_q;
  assign wr_req_data  = fifo_dout;
  assign busy         = (state_q == RUN) | (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign rsp_error    = rsp_error_q;

  // Job FSM plus the request register. armed_q keeps responses that belong to
  // a job aborted by reset from being reported as errors before the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      rsp_error_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      wr_valid_q <= fifo_re;
      if (fifo_re) begin
        wr_addr_q <= base_q + ADDR_WIDTH'(issued_q);
        issued_q  <= issued_q + 32'd1;
      end
      if (cred_underflow && armed_q) begin
        rsp_error_q <= 1'b1;
      end
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            base_q      <= base_addr;
            len_q       <= ctx_length;
            issued_q    <= '0;
            rsp_error_q <= 1'b0;
            armed_q     <= 1'b1;
            state_q     <= (ctx_length != '0) ? RUN : DRAIN;
          end
        end
        RUN: begin
          if (last_re) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cred_zero && !wr_valid_q) begin
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afu_write_drain.sv
// Directed bench for afu_write_drain: a FIFO model feeds numbered lines and a
// negedge monitor records every write request issued by the design.
module tb_afu_write_drain;

  localparam int AW = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [31:0]    ctx_length = '0;
  logic [511:0]   fifo_dout = '0;
  logic           fifo_empty;
  logic           fifo_re;
  logic           wr_req_almostfull = 1'b0;
  logic           wr_req_valid;
  logic [AW-1:0]  wr_req_addr;
  logic [511:0]   wr_req_data;
  logic           wr_rsp_valid = 1'b0;
  logic           busy;
  logic           done;
  logic           rsp_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  afu_write_drain #(.ADDR_WIDTH(AW), .CREDITS(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .ctx_length       (ctx_length),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_re          (fifo_re),
    .wr_req_almostfull(wr_req_almostfull),
    .wr_req_valid     (wr_req_valid),
    .wr_req_addr      (wr_req_addr),
    .wr_req_data      (wr_req_data),
    .wr_rsp_valid     (wr_rsp_valid),
    .busy             (busy),
    .done             (done),
    .rsp_error        (rsp_error)
  );

  // FIFO model: line k carries the pattern line(k); fifo_cnt is the absolute fill mark.
  int rd_ptr = 0;
  int fifo_cnt = 0;

  function automatic logic [511:0] line(input int k);
    return {16{32'hC0DE_0000 + 32'(k)}};
  endfunction

  assign fifo_empty = (rd_ptr >= fifo_cnt);

  always @(posedge clk) begin
    if (fifo_re) begin
      fifo_dout <= line(rd_ptr);
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Monitor: records requests, counts pops, and flags any valid not exactly one cycle after a pop.
  int           re_cnt = 0;
  int           lat_err = 0;
  logic         re_prev = 1'b0;
  logic [AW-1:0] wa_q[$];
  logic [511:0]  wd_q[$];

  always @(negedge clk) begin
    if (wr_req_valid === 1'b1) begin
      wa_q.push_back(wr_req_addr);
      wd_q.push_back(wr_req_data);
    end
    if (wr_req_valid !== re_prev) lat_err++;
    re_prev = fifo_re;
    if (fifo_re === 1'b1) re_cnt++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [31:0] n);
    base_addr  = b;
    ctx_length = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  // Acknowledge each observed write once, until the job reports done or the budget expires.
  task automatic finish_job(input int w0, input int n, input int pre, output bit ok);
    int sent;
    sent = pre;
    ok   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done === 1'b1 && sent == n) begin
        ok = 1'b1;
        break;
      end
      if (wa_q.size() - w0 > sent) begin
        wr_rsp_valid = 1'b1;
        sent++;
      end else begin
        wr_rsp_valid = 1'b0;
      end
      step();
    end
    wr_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step();
    checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL reset_fifo_re got %b want 0", fifo_re); end
    checks++; if (wr_req_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", wr_req_valid); end
    checks++; if (wr_req_addr !== 32'h0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", wr_req_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got %b want 0", rsp_error); end
  endtask

  task automatic test_basic();
    int w0 = wa_q.size();
    int r0 = re_cnt;
    int l0 = lat_err;
    int p0 = rd_ptr;
    bit ok;
    fifo_cnt = rd_ptr + 4;
    pulse_start(32'h1000, 32'd4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_run got %b want 1", busy); end
    finish_job(w0, 4, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got done=%b want done=1", done); end
    checks++; if (wa_q.size() - w0 !== 4) begin errors++; $display("FAIL basic_nwrites got %0d want 4", wa_q.size() - w0); end
    for (int k = 0; k < 4 && w0 + k < wa_q.size(); k++) begin
      checks++; if (wa_q[w0+k] !== 32'h1000 + 32'(k)) begin errors++; $display("FAIL basic_addr[%0d] got %h want %h", k, wa_q[w0+k], 32'h1000 + 32'(k)); end
      checks++; if (wd_q[w0+k] !== line(p0 + k)) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", k, wd_q[w0+k][31:0], 32'hC0DE_0000 + 32'(p0 + k)); end
    end
    checks++; if (re_cnt - r0 !== 4) begin errors++; $display("FAIL basic_re_count got %0d want 4", re_cnt - r0); end
    checks++; if (lat_err !== l0) begin errors++; $display("FAIL basic_latency got %0d misaligned want 0", lat_err - l0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL basic_rsp_error got %b want 0", rsp_error); end
  endtask

  task automatic test_zero_len();
    int r0 = re_cnt;
    fifo_cnt = rd_ptr + 2;
    pulse_start(32'h500, 32'd0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_drain got busy=%b done=%b want busy=1 done=0", busy, done); end
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done got busy=%b done=%b want busy=0 done=1", busy, done); end
    step(3);
    checks++; if (re_cnt !== r0) begin errors++; $display("FAIL zero_no_re got %0d pops want 0", re_cnt - r0); end
    fifo_cnt = rd_ptr;
  endtask

  task automatic test_credits();
    int w0 = wa_q.size();
    int r0 = re_cnt;
    int p0 = rd_ptr;
    bit ok;
    fifo_cnt = rd_ptr + 20;
    pulse_start(32'h4000, 32'd20);
    step(20);
    checks++; if (re_cnt - r0 !== 8) begin errors++; $display("FAIL credit_stall got %0d pops want 8", re_cnt - r0); end
    checks++; if (wa_q.size() - w0 !== 8) begin errors++; $display("FAIL credit_writes got %0d want 8", wa_q.size() - w0); end
    wr_rsp_valid = 1'b1;
    step();
    wr_rsp_valid = 1'b0;
    step(4);
    checks++; if (re_cnt - r0 !== 9) begin errors++; $display("FAIL credit_release1 got %0d pops want 9", re_cnt - r0); end
    // Second response coincides with the pop it enabled, so the count must not move that cycle.
    wr_rsp_valid = 1'b1;
    step(2);
    wr_rsp_valid = 1'b0;
    step(4);
    checks++; if (re_cnt - r0 !== 11) begin errors++; $display("FAIL credit_rsp_and_re got %0d pops want 11", re_cnt - r0); end
    finish_job(w0, 20, 3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL credit_timeout got done=%b want done=1", done); end
    checks++; if (wa_q.size() - w0 !== 20) begin errors++; $display("FAIL credit_nwrites got %0d want 20", wa_q.size() - w0); end
    for (int k = 0; k < 20 && w0 + k < wa_q.size(); k++) begin
      if (wa_q[w0+k] !== 32'h4000 + 32'(k) || wd_q[w0+k] !== line(p0 + k)) begin
        checks++; errors++;
        $display("FAIL credit_seq[%0d] got addr %h want %h", k, wa_q[w0+k], 32'h4000 + 32'(k));
      end else begin
        checks++;
      end
    end
  endtask

  task automatic test_almostfull();
    int w0 = wa_q.size();
    int p0 = rd_ptr;
    int r1;
    bit ok;
    fifo_cnt = rd_ptr + 12;
    pulse_start(32'h2000, 32'd12);
    step(2);
    wr_req_almostfull = 1'b1;
    #1;
    r1 = re_cnt;
    checks++; if (fifo_re !== 1'b0) begin errors++; $display("FAIL af_re_comb got %b want 0", fifo_re); end
    step(10);
    checks++; if (re_cnt !== r1) begin errors++; $display("FAIL af_no_re got %0d pops want 0", re_cnt - r1); end
    wr_req_almostfull = 1'b0;
    finish_job(w0, 12, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL af_timeout got done=%b want done=1", done); end
    checks++; if (wa_q.size() - w0 !== 12) begin errors++; $display("FAIL af_nwrites got %0d want 12", wa_q.size() - w0); end
    for (int k = 0; k < 12 && w0 + k < wa_q.size(); k++) begin
      checks++;
      if (wa_q[w0+k] !== 32'h2000 + 32'(k) || wd_q[w0+k] !== line(p0 + k)) begin
        errors++;
        $display("FAIL af_seq[%0d] got addr %h want %h", k, wa_q[w0+k], 32'h2000 + 32'(k));
      end
    end
  endtask

  task automatic test_wrap();
    int w0 = wa_q.size();
    bit ok;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFFE;
    exp_a[1] = 32'hFFFF_FFFF;
    exp_a[2] = 32'h0000_0000;
    exp_a[3] = 32'h0000_0001;
    fifo_cnt = rd_ptr + 4;
    pulse_start(32'hFFFF_FFFE, 32'd4);
    finish_job(w0, 4, 0, ok);
    checks++; if (!ok || wa_q.size() - w0 !== 4) begin errors++; $display("FAIL wrap_job got %0d writes done=%b want 4 done=1", wa_q.size() - w0, done); end
    for (int k = 0; k < 4 && w0 + k < wa_q.size(); k++) begin
      checks++; if (wa_q[w0+k] !== exp_a[k]) begin errors++; $display("FAIL wrap_addr[%0d] got %h want %h", k, wa_q[w0+k], exp_a[k]); end
    end
  endtask

  task automatic test_reset_midrun();
    int r0 = re_cnt;
    fifo_cnt = rd_ptr + 3;
    pulse_start(32'h3000, 32'd10);
    step(8);
    checks++; if (busy !== 1'b1 || re_cnt - r0 !== 3) begin errors++; $display("FAIL mid_setup got busy=%b pops=%0d want busy=1 pops=3", busy, re_cnt - r0); end
    reset = 1'b1;
    #1;
    checks++; if ({fifo_re, wr_req_valid, busy, done, rsp_error} !== 5'b0) begin errors++; $display("FAIL mid_reset_ctrl got %b want 00000", {fifo_re, wr_req_valid, busy, done, rsp_error}); end
    checks++; if (wr_req_addr !== 32'h0) begin errors++; $display("FAIL mid_reset_addr got %h want 0", wr_req_addr); end
    step();
    reset = 1'b0;
    step();
    wr_rsp_valid = 1'b1;
    step();
    wr_rsp_valid = 1'b0;
    step();
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL stray_rsp_after_reset got %b want 0", rsp_error); end
    fifo_cnt = rd_ptr;
    pulse_start(32'h0, 32'd0);
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL idle_job_done got %b want 1", done); end
    wr_rsp_valid = 1'b1;
    step();
    wr_rsp_valid = 1'b0;
    step();
    checks++; if (rsp_error !== 1'b1) begin errors++; $display("FAIL spurious_rsp got %b want 1", rsp_error); end
    step(3);
    checks++; if (rsp_error !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL sticky got rsp_error=%b done=%b want 1 1", rsp_error, done); end
    pulse_start(32'h0, 32'd0);
    checks++; if (rsp_error !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_clears got rsp_error=%b done=%b want 0 0", rsp_error, done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_credits();
    test_almostfull();
    test_wrap();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
